seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the CPU's combinational ALU.
- Keeps the existing ALUctl encodings and zero/blt flags.
- Adds signed/unsigned multiply, divide and remainder, computed iteratively (one bit per cycle).
- Sits between the ID/EX operand latch and EX/MEM; the pipeline stalls on in_ready/out_valid through a valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 4, power of two).
- CTL_W, 4, width of the ALUctl opcode field.
- CNT_W, $clog2(WIDTH)+1, iteration-counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/opcode present.
- in_ready  out  1  block can accept an operation this cycle.
- ALUctl  in  CTL_W  operation select, sampled on accept.
- A  in  WIDTH  operand A, signed, sampled on accept.
- B  in  WIDTH  operand B, signed, sampled on accept.
- out_valid  out  1  ALUOut/flags hold a completed result.
- out_ready  in  1  consumer takes the result this cycle.
- ALUOut  out  WIDTH  result.
- zero  out  1  ALUOut == 0.
- blt  out  1  ALUOut[WIDTH-1] (result negative, signed).
- illegal  out  1  accepted opcode was undefined.
- busy  out  1  multi-cycle op in progress (debug/stall).

Behaviour:
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0100 SLT (signed, result 1/0).
  - 0101 SLTU.
  - 1000 MUL (low WIDTH); 1001 MULH (signed x signed, high WIDTH); 1011 MULHU (unsigned high WIDTH).
  - 1100 DIV (signed); 1101 DIVU; 1110 REM (signed); 1111 REMU.
  - Any other code: ALUOut=0, illegal=1, 1-cycle latency.
- Arithmetic:
  - Two's complement, wrap on ADD/SUB overflow; no overflow flag.
  - MUL family uses a 2*WIDTH product register.
- Accept: in_valid && in_ready at a rising edge.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back single-cycle ops at full throughput.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: on accept of a single-cycle op, compute the result and go to DONE. On accept of a MUL-class op go to MUL; DIV-class go to DIV. Counter loads WIDTH.
  - MUL/DIV: one shift-add or restoring-subtract step per cycle; counter decrements. When the counter reaches 1, the final step writes the result and the FSM goes to DONE.
  - DONE: out_valid=1.
    - out_ready=0: hold.
    - out_ready=1 with a new accept: behave as the IDLE accept.
    - out_ready=1 with no accept: go to IDLE.
- Latency (accept at edge T):
  - Single-cycle ops: out_valid high after edge T+1... more precisely, out_valid is visible in the cycle following edge T.
  - MUL/DIV classes: out_valid is visible after edge T+WIDTH.
- Signed divide/multiply: take operand magnitudes and correct the sign at the final step.
- Divide special cases, resolved at accept, 1-cycle latency, skipping DIV:
  - B==0: DIV/DIVU give all-ones; REM/REMU give A.
  - Signed A==MIN and B==-1: DIV gives MIN; REM gives 0.
- Output stability:
  - ALUOut, zero, blt and illegal are registered.
  - They hold stable while out_valid && !out_ready.
  - They change only on entering DONE.
- busy = state in {MUL, DIV}. in_ready=0 while busy; in_valid during busy is ignored, not queued.
- Reset (sync, rst=1 at an edge):
  - state=IDLE; out_valid=0; ALUOut=0; zero=1; blt=0; illegal=0; busy=0; counter=0.
  - Reset mid-MUL/DIV aborts the operation; no result is produced.
- zero and blt are derived from the registered ALUOut, so they always match it.
- X-free: no x assignments. Undefined opcodes produce 0.

Decomposition:
- Shared package alu_pkg:
  - ALUctl localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_MUL, ALU_MULH, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU).
  - FSM state encoding.
  - Helper function is_mul/is_div.
- One sub-module is natural: seq_alu_divstep, a combinational one-bit restoring-divide step, WIDTH-parametrised.
- The shift-add multiply step stays inline.

Test Plan:
- Reset, then ADD A=7,B=-3 with out_ready=1 -> out_valid visible the next cycle, ALUOut=4, zero=0, blt=0. Follow with SUB 5,5 in the next cycle -> ALUOut=0, zero=1.
- SLT A=-1,B=1 -> 1; SLTU A=0xFFFFFFFF,B=1 -> 0; opcode 0011 -> ALUOut=0, illegal=1.
- MUL A=-2,B=3 -> ALUOut=0xFFFFFFFA exactly 32 cycles after accept, in_ready=0 throughout. MULH same operands -> 0xFFFFFFFF; MULHU 0xFFFFFFFF*2 -> 1.
- DIV -7/2 -> -3; REM -7/2 -> -1; DIVU 7/0 -> 0xFFFFFFFF (1-cycle); REM MIN/-1 -> 0; DIV MIN/-1 -> 0x80000000.
- Backpressure: hold out_ready=0 for 5 cycles after a DIV result -> ALUOut and flags are stable, in_ready=0. Raise out_ready together with a new in_valid -> handoff in the same cycle, no lost or duplicate result.
- Assert rst at cycle 10 of a MUL -> next cycle out_valid=0, ALUOut=0, zero=1, in_ready=1; a subsequent ADD 1+1 -> 2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and opcode-class definitions for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0100;
    localparam logic [3:0] ALU_SLTU  = 4'b0101;
    localparam logic [3:0] ALU_MUL   = 4'b1000;
    localparam logic [3:0] ALU_MULH  = 4'b1001;
    localparam logic [3:0] ALU_MULHU = 4'b1011;
    localparam logic [3:0] ALU_DIV   = 4'b1100;
    localparam logic [3:0] ALU_DIVU  = 4'b1101;
    localparam logic [3:0] ALU_REM   = 4'b1110;
    localparam logic [3:0] ALU_REMU  = 4'b1111;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [1:0] StDiv  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    function automatic logic is_mul(input logic [3:0] ctl);
        return (ctl == ALU_MUL) || (ctl == ALU_MULH) || (ctl == ALU_MULHU);
    endfunction

    function automatic logic is_div(input logic [3:0] ctl);
        return ctl[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/seq_alu_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial remainder and
// subtract the divisor if it fits.
module seq_alu_divstep #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        diff    = shifted - {1'b0, divisor_i};
        // diff[WIDTH] set means the divisor did not fit: restore.
        rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], ~diff[WIDTH]};
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/add ops plus iterative multiply and divide behind a
// valid/ready handshake with registered results.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CTL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CTL_W-1:0] ALUctl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUOut,
    output logic             zero,
    output logic             blt,
    output logic             illegal,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   alu_out_q, alu_out_d;
    logic               illegal_q, illegal_d;

    logic [3:0]         ctl;
    logic               ctl_ext_ok;
    logic               accept;
    logic               op_signed;
    logic               div_special;
    logic [WIDTH-1:0]   op_a, op_b;
    logic [WIDTH-1:0]   fast_res;
    logic               fast_ill;
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, mul_full;
    logic [WIDTH-1:0]   mul_res;
    logic [WIDTH-1:0]   div_rem, div_quo, div_res;

    assign ctl        = ALUctl[3:0];
    // Any set bit above the 4-bit opcode space makes the code undefined.
    assign ctl_ext_ok = (CTL_W <= 4) || ((ALUctl >> 4) == '0);
    assign in_ready   = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state_q == StDone);
    assign busy       = (state_q == StMul) || (state_q == StDiv);
    assign ALUOut     = alu_out_q;
    assign zero       = (alu_out_q == '0);
    assign blt        = alu_out_q[WIDTH-1];
    assign illegal    = illegal_q;

    always_comb begin
        op_signed   = (ctl == ALU_MUL) || (ctl == ALU_MULH) || (ctl == ALU_DIV) ||
                      (ctl == ALU_REM);
        op_a        = (op_signed && A[WIDTH-1]) ? -A : A;
        op_b        = (op_signed && B[WIDTH-1]) ? -B : B;
        div_special = ctl_ext_ok && is_div(ctl) &&
                      ((B == '0) ||
                       (((ctl == ALU_DIV) || (ctl == ALU_REM)) && (A == MinVal) && (B == '1)));
    end

    // Results that resolve in the accept cycle, including the divide corner cases.
    always_comb begin
        fast_res = '0;
        fast_ill = 1'b0;
        case (ctl)
            ALU_AND:  fast_res = A & B;
            ALU_OR:   fast_res = A | B;
            ALU_ADD:  fast_res = A + B;
            ALU_SUB:  fast_res = A - B;
            ALU_SLT:  fast_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLTU: fast_res = {{(WIDTH-1){1'b0}}, (A < B)};
            ALU_MUL, ALU_MULH, ALU_MULHU: fast_res = '0;
            ALU_DIV, ALU_DIVU: fast_res = (B == '0) ? '1 : MinVal;
            ALU_REM, ALU_REMU: fast_res = (B == '0) ? A : '0;
            default:  fast_ill = 1'b1;
        endcase
        if (!ctl_ext_ok) begin
            fast_res = '0;
            fast_ill = 1'b1;
        end
    end

    // Shift-add multiply: multiplier in the low half, partial product in the high half.
    always_comb begin
        mul_addend = acc_q[0] ? opb_q : '0;
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
        mul_next   = {mul_sum, acc_q[WIDTH-1:1]};
        mul_full   = neg_q ? -mul_next : mul_next;
        mul_res    = (op_q == ALU_MUL) ? mul_full[WIDTH-1:0] : mul_full[2*WIDTH-1:WIDTH];
    end

    seq_alu_divstep #(
        .WIDTH(WIDTH)
    ) u_divstep (
        .rem_i    (acc_q[2*WIDTH-1:WIDTH]),
        .quo_i    (acc_q[WIDTH-1:0]),
        .divisor_i(opb_q),
        .rem_o    (div_rem),
        .quo_o    (div_quo)
    );

    always_comb begin
        if ((op_q == ALU_DIV) || (op_q == ALU_DIVU)) begin
            div_res = neg_q ? -div_quo : div_quo;
        end else begin
            div_res = rneg_q ? -div_rem : div_rem;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        alu_out_d = alu_out_q;
        illegal_d = illegal_q;
        case (state_q)
            StMul: begin
                acc_d = mul_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    alu_out_d = mul_res;
                    illegal_d = 1'b0;
                    state_d   = StDone;
                end
            end
            StDiv: begin
                acc_d = {div_rem, div_quo};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    alu_out_d = div_res;
                    illegal_d = 1'b0;
                    state_d   = StDone;
                end
            end
            default: begin
                if (accept) begin
                    op_d   = ctl;
                    neg_d  = op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                    rneg_d = op_signed && A[WIDTH-1];
                    acc_d  = {{WIDTH{1'b0}}, op_a};
                    opb_d  = op_b;
                    if (ctl_ext_ok && is_mul(ctl)) begin
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = StMul;
                    end else if (ctl_ext_ok && is_div(ctl) && !div_special) begin
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = StDiv;
                    end else begin
                        alu_out_d = fast_res;
                        illegal_d = fast_ill;
                        state_d   = StDone;
                    end
                end else if ((state_q == StDone) && out_ready) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            acc_q     <= '0;
            opb_q     <= '0;
            alu_out_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            alu_out_q <= alu_out_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vectors, randomized ops against a 64-bit
// arithmetic reference, backpressure handoff and reset abort.
module tb_seq_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALUctl;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUOut;
    logic        zero;
    logic        blt;
    logic        illegal;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    seq_alu #(
        .WIDTH(32),
        .CTL_W(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ALUctl   (ALUctl),
        .A        (A),
        .B        (B),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ALUOut   (ALUOut),
        .zero     (zero),
        .blt      (blt),
        .illegal  (illegal),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        ill;
        int          lat;
    } vec_t;

    // Reference: results from 64-bit integer arithmetic; lat is edges after accept to result.
    function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
        longint          sa, sb, sp;
        longint unsigned up;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sp  = sa * sb;
        up  = {32'b0, a} * {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        ill = 1'b0;
        lat = 0;
        case (c)
            ALU_AND:   r = a & b;
            ALU_OR:    r = a | b;
            ALU_ADD:   r = a + b;
            ALU_SUB:   r = a - b;
            ALU_SLT:   r = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
            ALU_MUL:   begin r = sp[31:0];  lat = 32; end
            ALU_MULH:  begin r = sp[63:32]; lat = 32; end
            ALU_MULHU: begin r = up[63:32]; lat = 32; end
            ALU_DIV: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (ovf) r = 32'h8000_0000;
                else begin r = 32'(sa / sb); lat = 32; end
            end
            ALU_DIVU: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else begin r = a / b; lat = 32; end
            end
            ALU_REM: begin
                if (b == 0) r = a;
                else if (ovf) r = 32'd0;
                else begin r = 32'(sa % sb); lat = 32; end
            end
            ALU_REMU: begin
                if (b == 0) r = a;
                else begin r = a % b; lat = 32; end
            end
            default:   ill = 1'b1;
        endcase
    endfunction

    // Issue one op and wait (bounded) for its result; reports what was observed.
    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic ordy, output logic [31:0] res, output logic ill,
                          output logic z, output logic bl, output int lat,
                          output logic acc_ok, output logic busy_ok);
        @(negedge clk);
        ALUctl    = c;
        A         = a;
        B         = b;
        in_valid  = 1'b1;
        out_ready = ordy;
        #1;
        acc_ok = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 0;
        busy_ok  = 1'b1;
        while (!out_valid && lat < 200) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        res = ALUOut;
        ill = illegal;
        z   = zero;
        bl  = blt;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ALUctl    = '0;
        A         = '0;
        B         = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || ALUOut !== 32'd0 || zero !== 1'b1 || blt !== 1'b0 ||
            illegal !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: got ov=%b out=%h z=%b blt=%b ill=%b busy=%b rdy=%b, need 0 0 1 0 0 0 1",
                     out_valid, ALUOut, zero, blt, illegal, busy, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        vec_t        v[18];
        logic [31:0] res;
        logic        ill, z, bl, acc_ok, busy_ok;
        int          lat;
        v[0]  = '{ALU_ADD,   32'd7,          32'hFFFF_FFFD, 32'd4,          1'b0, 0};
        v[1]  = '{ALU_SUB,   32'd5,          32'd5,         32'd0,          1'b0, 0};
        v[2]  = '{ALU_SLT,   32'hFFFF_FFFF,  32'd1,         32'd1,          1'b0, 0};
        v[3]  = '{ALU_SLTU,  32'hFFFF_FFFF,  32'd1,         32'd0,          1'b0, 0};
        v[4]  = '{4'b0011,   32'd9,          32'd9,         32'd0,          1'b1, 0};
        v[5]  = '{ALU_AND,   32'h0000_F0F0,  32'h0000_FF00, 32'h0000_F000,  1'b0, 0};
        v[6]  = '{ALU_OR,    32'h0000_F0F0,  32'h0000_FF00, 32'h0000_FFF0,  1'b0, 0};
        v[7]  = '{ALU_MUL,   32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFA,  1'b0, 32};
        v[8]  = '{ALU_MULH,  32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF,  1'b0, 32};
        v[9]  = '{ALU_MULHU, 32'hFFFF_FFFF,  32'd2,         32'd1,          1'b0, 32};
        v[10] = '{ALU_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD,  1'b0, 32};
        v[11] = '{ALU_REM,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF,  1'b0, 32};
        v[12] = '{ALU_DIVU,  32'd7,          32'd0,         32'hFFFF_FFFF,  1'b0, 0};
        v[13] = '{ALU_REM,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,          1'b0, 0};
        v[14] = '{ALU_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000,  1'b0, 0};
        v[15] = '{ALU_REMU,  32'd7,          32'd0,         32'd7,          1'b0, 0};
        v[16] = '{ALU_DIVU,  32'd100,        32'd7,         32'd14,         1'b0, 32};
        v[17] = '{ALU_REMU,  32'd100,        32'd7,         32'd2,          1'b0, 32};
        for (int i = 0; i < 18; i++) begin
            run_op(v[i].c, v[i].a, v[i].b, 1'b1, res, ill, z, bl, lat, acc_ok, busy_ok);
            n_checks++;
            if (res !== v[i].r) begin
                n_fail++;
                $display("FAIL dir_result[%0d]: got %h, need %h", i, res, v[i].r);
            end
            n_checks++;
            if (ill !== v[i].ill || z !== (v[i].r == 0) || bl !== v[i].r[31]) begin
                n_fail++;
                $display("FAIL dir_flags[%0d]: got ill=%b z=%b blt=%b, need ill=%b z=%b blt=%b",
                         i, ill, z, bl, v[i].ill, (v[i].r == 0), v[i].r[31]);
            end
            n_checks++;
            if (lat != v[i].lat) begin
                n_fail++;
                $display("FAIL dir_latency[%0d]: got %0d, need %0d", i, lat, v[i].lat);
            end
            n_checks++;
            if (acc_ok !== 1'b1 || busy_ok !== 1'b1) begin
                n_fail++;
                $display("FAIL dir_handshake[%0d]: got accept=%b busy_ok=%b, need 1 1",
                         i, acc_ok, busy_ok);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0]  c;
        logic [31:0] a, b, res, er;
        logic        ill, z, bl, acc_ok, busy_ok, eill;
        int          lat, elat;
        for (int i = 0; i < 60; i++) begin
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($signed(8'($urandom))); b = 32'($signed(8'($urandom))); end
                default: ;
            endcase
            model(c, a, b, er, eill, elat);
            run_op(c, a, b, 1'b1, res, ill, z, bl, lat, acc_ok, busy_ok);
            n_checks++;
            if (res !== er || ill !== eill || z !== (er == 0) || bl !== er[31]) begin
                n_fail++;
                $display("FAIL rnd_result[%0d] op=%b a=%h b=%h: got %h ill=%b z=%b blt=%b, need %h ill=%b",
                         i, c, a, b, res, ill, z, bl, er, eill);
            end
            n_checks++;
            if (lat != elat || acc_ok !== 1'b1 || busy_ok !== 1'b1) begin
                n_fail++;
                $display("FAIL rnd_timing[%0d] op=%b: got lat=%0d acc=%b busy_ok=%b, need lat=%0d",
                         i, c, lat, acc_ok, busy_ok, elat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        logic        ill, z, bl, acc_ok, busy_ok;
        int          lat;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        run_op(ALU_DIVU, 32'd100, 32'd7, 1'b0, res, ill, z, bl, lat, acc_ok, busy_ok);
        n_checks++;
        if (res !== 32'd14 || lat != 32 || acc_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first: got %h lat=%0d acc=%b, need 0000000e lat=32 acc=1",
                     res, lat, acc_ok);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || ALUOut !== 32'd14 || zero !== 1'b0 || blt !== 1'b0 ||
                in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got ov=%b out=%h z=%b blt=%b rdy=%b, need 1 0000000e 0 0 0",
                         i, out_valid, ALUOut, zero, blt, in_ready);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        ALUctl    = ALU_ADD;
        A         = 32'd20;
        B         = 32'd22;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_handoff_ready: got %b, need 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || ALUOut !== 32'd42) begin
            n_fail++;
            $display("FAIL bp_handoff_result: got ov=%b out=%h, need 1 0000002a", out_valid, ALUOut);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || ALUOut !== 32'd42) begin
            n_fail++;
            $display("FAIL bp_no_duplicate: got ov=%b out=%h, need 0 0000002a", out_valid, ALUOut);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] res;
        logic        ill, z, bl, acc_ok, busy_ok;
        int          lat;
        @(negedge clk);
        ALUctl    = ALU_MUL;
        A         = 32'hFFFF_FFFE;
        B         = 32'd3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_busy: got %b, need 1", busy);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || ALUOut !== 32'd0 || zero !== 1'b1 || in_ready !== 1'b1 ||
            busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_state: got ov=%b out=%h z=%b rdy=%b busy=%b, need 0 0 1 1 0",
                     out_valid, ALUOut, zero, in_ready, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_no_result: got ov=%b, need 0", out_valid);
        end
        run_op(ALU_ADD, 32'd1, 32'd1, 1'b1, res, ill, z, bl, lat, acc_ok, busy_ok);
        n_checks++;
        if (res !== 32'd2 || lat != 0 || acc_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_after_add: got %h lat=%0d acc=%b, need 00000002 0 1",
                     res, lat, acc_ok);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
